// File: rtl/regfile_pkg.sv
// ============================================================================
// regfile_pkg : shared defaults for the 2R1W register file
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;
  localparam int DATA_WIDTH_DEFAULT = 32;
  localparam int ADDR_WIDTH_DEFAULT = 5;
  localparam int ZERO_REG           = 0;
  localparam int RESET_DATA         = 0;
endpackage

`default_nettype wire

// File: rtl/regfile_read_port.sv
// ============================================================================
// regfile_read_port : one registered read port with zero-index forcing,
// optional write-through (REGFILE_BYPASS_EN) and stall hold
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] entry_data,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] data
);

  logic [DATA_WIDTH-1:0] next_data;

`ifdef REGFILE_BYPASS_EN
  always_comb begin
    next_data = entry_data;
    if (addr == ADDR_WIDTH'(ZERO_REG)) begin
      next_data = DATA_WIDTH'(RESET_DATA);
    end else if (wr_en && (wr_addr == addr)) begin
      // addr is nonzero here, so wr_addr is nonzero too
      next_data = wr_data;
    end
  end
`else
  // Without write-through the same-edge write is invisible: pre-write value wins
  logic unused_bypass_inputs;
  assign unused_bypass_inputs = ^{wr_en, wr_addr, wr_data};

  always_comb begin
    next_data = entry_data;
    if (addr == ADDR_WIDTH'(ZERO_REG)) begin
      next_data = DATA_WIDTH'(RESET_DATA);
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data <= DATA_WIDTH'(RESET_DATA);
    end else if (!stall && rd_req) begin
      data <= next_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/register_file_2r1w.sv
// ============================================================================
// register_file_2r1w : two-read/one-write register file, 1-cycle read latency
// Optional write-to-read bypass enabled by defining REGFILE_BYPASS_EN
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module register_file_2r1w
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_req,
  input  logic                  stall,
  input  logic [ADDR_WIDTH-1:0] rd_addr_a,
  input  logic [ADDR_WIDTH-1:0] rd_addr_b,
  output logic [DATA_WIDTH-1:0] rd_data_a,
  output logic [DATA_WIDTH-1:0] rd_data_b,
  output logic                  rd_valid
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] entries [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= DATA_WIDTH'(RESET_DATA);
      end
      rd_valid <= 1'b0;
    end else begin
      if (wr_en && (wr_addr != ADDR_WIDTH'(ZERO_REG))) begin
        entries[wr_addr] <= wr_data;
      end
      if (!stall) begin
        rd_valid <= rd_req;
      end
    end
  end

  regfile_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_port_a (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .rd_req     (rd_req),
    .addr       (rd_addr_a),
    .entry_data (entries[rd_addr_a]),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .data       (rd_data_a)
  );

  regfile_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_port_b (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .rd_req     (rd_req),
    .addr       (rd_addr_b),
    .entry_data (entries[rd_addr_b]),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .data       (rd_data_b)
  );

endmodule

`default_nettype wire

// File: tb/tb_register_file_2r1w.sv
// ============================================================================
// tb_register_file_2r1w : directed self-checking bench for register_file_2r1w
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_register_file_2r1w;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rd_req;
  logic        stall;
  logic [4:0]  rd_addr_a;
  logic [4:0]  rd_addr_b;
  logic [31:0] rd_data_a;
  logic [31:0] rd_data_b;
  logic        rd_valid;

  int n_checks = 0;
  int n_pass   = 0;

  register_file_2r1w dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_req    (rd_req),
    .stall     (stall),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .rd_valid  (rd_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_io(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic rq, input logic st, input logic [4:0] aa, input logic [4:0] ab);
    wr_en = we; wr_addr = wa; wr_data = wd;
    rd_req = rq; stall = st; rd_addr_a = aa; rd_addr_b = ab;
  endtask

  initial begin
    reset = 1'b0;
    set_io(1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd5, 5'd5);

    // Reset held across three edges with rd_req asserted
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_valid", {31'b0, rd_valid}, 32'h0);
      check("reset_data_a", rd_data_a, 32'h0);
      check("reset_data_b", rd_data_b, 32'h0);
    end
    reset = 1'b1;
    tick();
    check("post_reset_valid", {31'b0, rd_valid}, 32'h1);
    check("post_reset_idx5", rd_data_a, 32'h0);

    // Write index 7, read both ports from it
    set_io(1'b1, 5'd7, 32'h0000_00AB, 1'b0, 1'b0, 5'd0, 5'd0);
    tick();
    check("idle_valid", {31'b0, rd_valid}, 32'h0);
    set_io(1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd7, 5'd7);
    tick();
    check("rd7_valid", {31'b0, rd_valid}, 32'h1);
    check("rd7_a", rd_data_a, 32'h0000_00AB);
    check("rd7_b", rd_data_b, 32'h0000_00AB);

    // Index 0 ignores writes
    set_io(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 5'd0, 5'd0);
    tick();
    set_io(1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd0, 5'd7);
    tick();
    check("rd0_valid", {31'b0, rd_valid}, 32'h1);
    check("rd0_a", rd_data_a, 32'h0);
    check("rd0_b_idx7", rd_data_b, 32'h0000_00AB);

    // Same-edge write/read hazard on index 3
    set_io(1'b1, 5'd3, 32'h11, 1'b0, 1'b0, 5'd0, 5'd0);
    tick();
    set_io(1'b1, 5'd4, 32'h44, 1'b0, 1'b0, 5'd0, 5'd0);
    tick();
    set_io(1'b1, 5'd3, 32'h22, 1'b1, 1'b0, 5'd3, 5'd4);
    tick();
`ifdef REGFILE_BYPASS_EN
    check("hazard_a", rd_data_a, 32'h22);
`else
    check("hazard_a", rd_data_a, 32'h11);
`endif
    check("hazard_b", rd_data_b, 32'h44);
    set_io(1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd3, 5'd3);
    tick();
    check("after_hazard_a", rd_data_a, 32'h22);

    // Stall holds a snapshot despite writes and rd_req toggling
    set_io(1'b1, 5'd9, 32'h99, 1'b0, 1'b0, 5'd0, 5'd0);
    tick();
    set_io(1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd9, 5'd3);
    tick();
    check("rd9_a", rd_data_a, 32'h99);
    check("rd9_valid", {31'b0, rd_valid}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      set_io((i == 0), 5'd9, 32'h55, (i % 2 == 1), 1'b1, 5'd9, 5'd9);
      tick();
      check("stall_a", rd_data_a, 32'h99);
      check("stall_b", rd_data_b, 32'h22);
      check("stall_valid", {31'b0, rd_valid}, 32'h1);
    end
    set_io(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd9, 5'd9);
    tick();
    check("unstall_valid", {31'b0, rd_valid}, 32'h0);
    check("unstall_hold_a", rd_data_a, 32'h99);
    set_io(1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd9, 5'd7);
    tick();
    check("rd9_new_a", rd_data_a, 32'h55);
    check("rd9_new_b", rd_data_b, 32'h0000_00AB);

    // Asynchronous reset pulse between edges
    check("pre_async_valid", {31'b0, rd_valid}, 32'h1);
    reset = 1'b0;
    #2;
    check("async_valid", {31'b0, rd_valid}, 32'h0);
    check("async_a", rd_data_a, 32'h0);
    check("async_b", rd_data_b, 32'h0);
    reset = 1'b1;
    set_io(1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd7, 5'd9);
    tick();
    check("post_async_valid", {31'b0, rd_valid}, 32'h1);
    check("post_async_a", rd_data_a, 32'h0);
    check("post_async_b", rd_data_b, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/register_file_2r1w.md
# register_file_2r1w

Two-read/one-write register file for the MIPS pipeline's decode stage: the read side paired with the existing single-port write register. Each edge it accepts one write (from writeback) and one two-operand read request (from decode). Read results are registered, giving one-cycle latency with a valid flag, a stall hold, and an optional write-to-read bypass.

## Interface
- DATA_WIDTH, 32, width of each register and data port
- ADDR_WIDTH, 5, register index width; depth is 2**ADDR_WIDTH
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- wr_en  input  1  write strobe
- wr_addr  input  ADDR_WIDTH  write index
- wr_data  input  DATA_WIDTH  write data
- rd_req  input  1  read request, both ports
- stall  input  1  freeze read pipeline
- rd_addr_a  input  ADDR_WIDTH  port A index
- rd_addr_b  input  ADDR_WIDTH  port B index
- rd_data_a  output  DATA_WIDTH  registered port A data
- rd_data_b  output  DATA_WIDTH  registered port B data
- rd_valid  output  1  rd_data_a/b hold a completed read

## Operation
- Reset asserted (reset=0), asynchronously: all entries, rd_data_a, rd_data_b = 0; rd_valid = 0. This holds until the first rising edge after release.
- Write: on a rising edge with wr_en=1 and wr_addr!=0, the entry is updated. Writes to index 0 are discarded. Writes are independent of stall and rd_req.
- Index 0 always reads 0.
- Read pipeline, evaluated each rising edge:
  - stall=1: rd_data_a/b and rd_valid hold. rd_req is ignored and the request is lost; the requester holds it.
  - stall=0, rd_req=1: rd_data_x <= entry[rd_addr_x]; rd_valid <= 1.
  - stall=0, rd_req=0: rd_valid <= 0; rd_data_x hold the last value.
- Held data is a snapshot. A write to that index during stall does not refresh rd_data.
- rd_addr_a == rd_addr_b is legal; both ports return identical data.
- Same-edge write and read of the same nonzero index: the result depends on the Configuration section.

## Timing
- Read latency: 1 cycle. Address at edge N gives data and rd_valid=1 after edge N.
- Write visible to a non-bypassed read issued on edge N+1 or later when written on edge N.
- Throughput: one read pair per cycle while stall=0.
- Reset release: first read completes one edge after release.
- No combinational path from any input to any output.

## Configuration
- REGFILE_BYPASS_EN defined: when wr_en=1, wr_addr!=0 and wr_addr==rd_addr_x on a capturing edge, rd_data_x <= wr_data (write-through). This applies per port independently.
- REGFILE_BYPASS_EN undefined: the same case captures the pre-write entry value. Writeback must then lead decode by one cycle.

## Structure
- Shared package regfile_pkg: DATA_WIDTH/ADDR_WIDTH defaults, ZERO_REG = 0, reset data value 0.
- One sub-module, regfile_read_port, instantiated twice. It contains the index-0 check, the bypass mux under the macro, and the output register with stall hold.
- Storage array, write logic and rd_valid live in the top module.

## Test plan
- Reset: hold reset=0 for 3 cycles with rd_req=1 -> rd_valid=0, rd_data_a/b=0 throughout. After release, a read of index 5 returns 0 one cycle later.
- Write/read: write 0x0000_00AB to index 7, then read A=7, B=7 next cycle -> both 0x0000_00AB, rd_valid=1 one cycle after the request.
- Index 0: write 0xFFFF_FFFF to index 0, read A=0 -> 0, rd_valid=1.
- Same-edge hazard: index 3 holds 0x11; write 0x22 to index 3 while reading A=3 on the same edge -> 0x22 with REGFILE_BYPASS_EN, 0x11 without. B=4 is unaffected in both builds.
- Stall: read index 9 (0x99) completes, then stall=1 for 4 cycles while index 9 is written 0x55 and rd_req toggles -> rd_data_a stays 0x99, rd_valid stays 1. After stall=0 with rd_req=0, rd_valid drops next edge.
- Async reset mid-stream: pulse reset=0 between edges while rd_valid=1 -> outputs clear immediately without a clock edge, and a later read of a previously written index returns 0.
